// File: rtl/ifft8_stream_if.sv
// Sample-stream bundle for ifft8_stream: frequency-domain samples in, time-domain samples out.
interface ifft8_stream_if #(parameter int W = 8);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_re;
  logic signed [W-1:0] in_im;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_re;
  logic signed [W-1:0] out_im;
  logic                out_last;
  logic                busy;

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_last, busy
  );

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_last, busy
  );
endinterface

// File: rtl/ifft8_stream.sv
// Streaming 8-point radix-2 DIT inverse FFT with one time-shared butterfly and 1/8 output scaling.
module ifft8_stream #(
  parameter int W = 8
) (
  input logic            clk,
  input logic            rst,
  ifft8_stream_if.slave  strm
);
  localparam int BW = W + 4;

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

  state_t state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;

  logic signed [BW-1:0] bank_re [8];
  logic signed [BW-1:0] bank_im [8];

  logic load_fire, unload_fire;
  logic [2:0] rev_idx;

  assign load_fire   = (state_reg == LOAD) && strm.in_valid;
  assign unload_fire = (state_reg == UNLOAD) && strm.out_ready;
  assign rev_idx     = {cnt_reg[0], cnt_reg[1], cnt_reg[2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= LOAD;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // One counter serves as k in LOAD, b in COMPUTE and n in UNLOAD.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      LOAD: begin
        if (load_fire) begin
          cnt_next = cnt_reg + 4'd1;
          if (cnt_reg == 4'd7) begin
            state_next = COMPUTE;
            cnt_next   = '0;
          end
        end
      end
      COMPUTE: begin
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == 4'd11) begin
          state_next = UNLOAD;
          cnt_next   = '0;
        end
      end
      UNLOAD: begin
        if (unload_fire) begin
          cnt_next = cnt_reg + 4'd1;
          if (cnt_reg == 4'd7) begin
            state_next = LOAD;
            cnt_next   = '0;
          end
        end
      end
      default: begin
        state_next = LOAD;
        cnt_next   = '0;
      end
    endcase
  end

  // Butterfly schedule: cnt[3:2] is the stage, cnt[1:0] the butterfly within it.
  logic [2:0] a_idx, b_idx;
  logic [1:0] tw;

  always_comb begin
    a_idx = '0;
    b_idx = '0;
    tw    = '0;
    unique case (cnt_reg[3:2])
      2'd0: begin
        a_idx = {cnt_reg[1:0], 1'b0};
        b_idx = {cnt_reg[1:0], 1'b1};
      end
      2'd1: begin
        a_idx = {cnt_reg[1], 1'b0, cnt_reg[0]};
        b_idx = {cnt_reg[1], 1'b1, cnt_reg[0]};
        tw    = {cnt_reg[0], 1'b0};
      end
      default: begin
        a_idx = {1'b0, cnt_reg[1:0]};
        b_idx = {1'b1, cnt_reg[1:0]};
        tw    = cnt_reg[1:0];
      end
    endcase
  end

  localparam logic signed [BW+9:0] C181 = 181;
  localparam logic signed [BW+9:0] C128 = 128;

  // Multiply by 181/256 (~1/sqrt2), rounding half up.
  function automatic logic signed [BW-1:0] rnd(input logic signed [BW:0] v);
    logic signed [BW+9:0] p;
    p = {{9{v[BW]}}, v} * C181 + C128;
    return BW'(p >>> 8);
  endfunction

  logic signed [BW-1:0] a_re, a_im, b_re, b_im, t_re, t_im;
  logic signed [BW:0]   b_dif, b_sum;

  always_comb begin
    a_re  = bank_re[a_idx];
    a_im  = bank_im[a_idx];
    b_re  = bank_re[b_idx];
    b_im  = bank_im[b_idx];
    b_dif = {b_re[BW-1], b_re} - {b_im[BW-1], b_im};
    b_sum = {b_re[BW-1], b_re} + {b_im[BW-1], b_im};
    t_re  = b_re;
    t_im  = b_im;
    unique case (tw)
      2'd1: begin
        t_re = rnd(b_dif);
        t_im = rnd(b_sum);
      end
      2'd2: begin
        t_re = -b_im;
        t_im = b_re;
      end
      2'd3: begin
        t_re = -rnd(b_sum);
        t_im = rnd(b_dif);
      end
      default: begin
        t_re = b_re;
        t_im = b_im;
      end
    endcase
  end

  // Bank has no reset; samples land bit-reversed so the butterflies can run in place.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load_fire) begin
        bank_re[rev_idx] <= {{4{strm.in_re[W-1]}}, strm.in_re};
        bank_im[rev_idx] <= {{4{strm.in_im[W-1]}}, strm.in_im};
      end else if (state_reg == COMPUTE) begin
        bank_re[a_idx] <= a_re + t_re;
        bank_im[a_idx] <= a_im + t_im;
        bank_re[b_idx] <= a_re - t_re;
        bank_im[b_idx] <= a_im - t_im;
      end
    end
  end

  localparam logic signed [BW:0]   RND4 = 4;
  localparam logic signed [BW-3:0] MAXV = 2 ** (W - 1) - 1;
  localparam logic signed [BW-3:0] MINV = -(2 ** (W - 1));

  logic out_active;
  assign out_active = (state_reg == UNLOAD);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_part
      logic signed [BW-1:0] v;
      logic signed [BW:0]   rs;
      logic signed [BW-3:0] sh;
      logic signed [W-1:0]  q;
      assign v  = (gi == 0) ? bank_re[cnt_reg[2:0]] : bank_im[cnt_reg[2:0]];
      assign rs = {v[BW-1], v} + RND4;
      assign sh = (BW-2)'(rs >>> 3);
      assign q  = (sh > MAXV) ? MAXV[W-1:0] :
                  (sh < MINV) ? MINV[W-1:0] : sh[W-1:0];
    end
  endgenerate

  assign strm.in_ready  = (state_reg == LOAD);
  assign strm.out_valid = out_active;
  assign strm.out_re    = out_active ? g_part[0].q : '0;
  assign strm.out_im    = out_active ? g_part[1].q : '0;
  assign strm.out_last  = out_active && (cnt_reg == 4'd7);
  assign strm.busy      = (state_reg != LOAD);
endmodule

// File: tb/tb_ifft8_stream.sv
// Directed bench for ifft8_stream: fixed-point IFFT reference model plus a per-cycle output checker.
module tb_ifft8_stream;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifft8_stream_if #(.W(W)) bus();

  ifft8_stream #(.W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .strm (bus)
  );

  int checks = 0;
  int errors = 0;

  int exp_re[$];
  int exp_im[$];
  int beat = 0;
  bit bp_mode = 1'b0;

  int m_re[8], m_im[8];   // unscaled time-domain result
  int e_re[8], e_im[8];   // scaled and saturated result

  int imp_re[8]  = '{8, 0, 0, 0, 0, 0, 0, 0};
  int zero8[8]   = '{0, 0, 0, 0, 0, 0, 0, 0};
  int flat_re[8] = '{8, 8, 8, 8, 8, 8, 8, 8};
  int bin_re[8]  = '{0, 64, 0, 0, 0, 0, 0, 0};
  int sat_re[8]  = '{127, 0, -128, 0, 127, 0, -128, 0};
  int sat_im[8]  = '{0, -128, 0, 127, 0, -128, 0, 127};
  int mix_re[8]  = '{10, -20, 5, -128, 0, 33, -7, 100};
  int mix_im[8]  = '{-3, 7, 5, 127, -1, -44, 12, -100};
  int bin_exp_re[8] = '{8, 6, 0, -6, -8, -6, 0, 6};
  int bin_exp_im[8] = '{0, 6, 8, 6, 0, -6, -8, -6};

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int r181(input int v);
    return (v * 181 + 128) >>> 8;
  endfunction

  function automatic int sat8(input int v);
    int s;
    s = (v + 4) >>> 3;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  // Textbook iterative DIT: bit-reverse, then span-doubling stages with twiddle j*8/size.
  function automatic void run_model(input int xr[8], input int xi[8]);
    int ar[8], ai[8];
    int size, half, p, q, k, br, bi, tr, ti, rv;
    for (int i = 0; i < 8; i++) begin
      rv = ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
      ar[i] = xr[rv];
      ai[i] = xi[rv];
    end
    size = 2;
    while (size <= 8) begin
      half = size / 2;
      for (int s = 0; s < 8; s += size) begin
        for (int j = 0; j < half; j++) begin
          p = s + j;
          q = p + half;
          k = j * (8 / size);
          br = ar[q];
          bi = ai[q];
          case (k)
            1: begin tr = r181(br - bi);  ti = r181(br + bi); end
            2: begin tr = -bi;            ti = br;            end
            3: begin tr = -r181(br + bi); ti = r181(br - bi); end
            default: begin tr = br; ti = bi; end
          endcase
          ar[q] = ar[p] - tr;
          ai[q] = ai[p] - ti;
          ar[p] = ar[p] + tr;
          ai[p] = ai[p] + ti;
        end
      end
      size = size * 2;
    end
    for (int i = 0; i < 8; i++) begin
      m_re[i] = ar[i];
      m_im[i] = ai[i];
      e_re[i] = sat8(ar[i]);
      e_im[i] = sat8(ai[i]);
    end
  endfunction

  task automatic send_frame(input int xr[8], input int xi[8], input bit chk_lat);
    int t;
    int lat;
    run_model(xr, xi);
    for (int i = 0; i < 8; i++) begin
      exp_re.push_back(e_re[i]);
      exp_im.push_back(e_im[i]);
    end
    for (int k = 0; k < 8; k++) begin
      bus.in_valid = 1'b1;
      bus.in_re = 8'(xr[k]);
      bus.in_im = 8'(xi[k]);
      t = 0;
      @(negedge clk);
      while (!bus.in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) chk("in_ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      $display("in  k=%0d re=%0d im=%0d", k, xr[k], xi[k]);
    end
    bus.in_valid = 1'b0;
    if (chk_lat) begin
      lat = 0;
      @(negedge clk);
      while (!bus.out_valid && lat < 40) begin
        lat++;
        @(negedge clk);
      end
      chk("latency", lat, 12);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_re.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    chk("drain_left", exp_re.size(), 0);
    #1;
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output checker: every cycle, valid beats against the model queue, idle cycles against zero.
  initial begin
    bit stalled;
    int held;
    stalled = 1'b0;
    held = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.out_valid) begin
          if (stalled) chk("stall_hold", int'({bus.out_re, bus.out_im, bus.out_last}), held);
          chk("in_ready_unload", int'(bus.in_ready), 0);
          if (exp_re.size() == 0) begin
            chk("unexpected_out", 1, 0);
          end else begin
            chk("out_re", int'(bus.out_re), exp_re[0]);
            chk("out_im", int'(bus.out_im), exp_im[0]);
            chk("out_last", int'(bus.out_last), (beat == 7) ? 1 : 0);
            if (bus.out_ready) begin
              $display("out n=%0d re=%0d im=%0d last=%0d", beat, bus.out_re, bus.out_im, bus.out_last);
              void'(exp_re.pop_front());
              void'(exp_im.pop_front());
              beat = (beat + 1) % 8;
            end
          end
          stalled = !bus.out_ready;
          held = int'({bus.out_re, bus.out_im, bus.out_last});
        end else begin
          chk("idle_zero", int'({bus.out_re, bus.out_im, bus.out_last}), 0);
          stalled = 1'b0;
        end
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_re = '0;
    bus.in_im = '0;

    // Model pinned to hand-derived results.
    run_model(imp_re, zero8);
    for (int i = 0; i < 8; i++) chk("model_impulse", e_re[i] * 1000 + e_im[i], 1000);
    run_model(flat_re, zero8);
    chk("model_flat0", e_re[0], 8);
    for (int i = 1; i < 8; i++) chk("model_flat", e_re[i] * 1000 + e_im[i], 0);
    run_model(bin_re, zero8);
    for (int i = 0; i < 8; i++) begin
      chk("model_bin_re", e_re[i], bin_exp_re[i]);
      chk("model_bin_im", e_im[i], bin_exp_im[i]);
    end
    run_model(sat_re, sat_im);
    chk("model_sat_raw2", m_re[2], 1020);
    chk("model_sat_x2", e_re[2] * 1000 + e_im[2], 127000);
    chk("model_sat_x6", e_re[6] * 1000 + e_im[6], 0);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_last", int'(bus.out_last), 0);
    chk("rst_busy", int'(bus.busy), 0);
    @(posedge clk);
    #1;

    send_frame(imp_re, zero8, 1'b1);
    wait_drain();
    chk("in_ready_after_frame", int'(bus.in_ready), 1);
    send_frame(flat_re, zero8, 1'b0);
    wait_drain();
    send_frame(bin_re, zero8, 1'b1);
    wait_drain();
    send_frame(sat_re, sat_im, 1'b0);
    wait_drain();
    send_frame(mix_re, mix_im, 1'b0);
    wait_drain();

    // Backpressure with in_valid held high through COMPUTE and UNLOAD.
    bp_mode = 1'b1;
    send_frame(imp_re, zero8, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_re = 8'sd55;
    bus.in_im = -8'sd9;
    wait_drain();
    bus.in_valid = 1'b0;
    bp_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("no_extra_load_busy", int'(bus.busy), 0);

    // Abort in COMPUTE at b=5.
    send_frame(imp_re, zero8, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("busy_compute", int'(bus.busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_re.delete();
    exp_im.delete();
    beat = 0;
    @(negedge clk);
    chk("abort_out_valid", int'(bus.out_valid), 0);
    chk("abort_in_ready", int'(bus.in_ready), 1);
    chk("abort_busy", int'(bus.busy), 0);
    @(posedge clk);
    #1;
    send_frame(imp_re, zero8, 1'b1);
    wait_drain();

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
